pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use interlock, EX-resolved
// branch flush, imem wait-state bubbles, debug halt/resume and stall/flush perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             branch_taken_i,
    input  logic             imem_valid_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic             pc_en_o,
    output logic             pc_sel_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {StRun, StStall, StHalt} state_e;

    localparam logic [3:0]       StallInit = 4'(LOAD_USE_STALL - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_d;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_hazard;

    assign w_rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign w_rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign w_hazard  = ex_mem_read_i && (ex_rd_i != 5'd0) && (w_rs1_hit || w_rs2_hit);

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        pc_en_o       = 1'b1;
        pc_sel_o      = 1'b0;
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        halted_o      = 1'b0;

        unique case (r_state)
            StRun: begin
                if (branch_taken_i) begin
                    pc_sel_o      = 1'b1;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    w_flush_inc   = 1'b1;
                end else if (w_hazard) begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                    w_stall_inc   = 1'b1;
                    if (LOAD_USE_STALL > 1) begin
                        w_state_d = StStall;
                        w_cnt_d   = StallInit;
                    end
                end else if (halt_req_i) begin
                    w_state_d = StHalt;
                end else if (!imem_valid_i) begin
                    pc_en_o       = 1'b0;
                    if_id_flush_o = 1'b1;
                end
            end
            StStall: begin
                // A branch landing mid-stall still counts as a lost stall cycle.
                w_stall_inc = 1'b1;
                w_cnt_d     = r_cnt - 4'd1;
                if (branch_taken_i) begin
                    pc_sel_o      = 1'b1;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    w_flush_inc   = 1'b1;
                    w_state_d     = StRun;
                    w_cnt_d       = 4'd0;
                end else begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                    if (r_cnt == 4'd1) begin
                        w_state_d = StRun;
                    end
                end
            end
            StHalt: begin
                halted_o      = 1'b1;
                if_id_en_o    = 1'b0;
                id_ex_flush_o = 1'b1;
                if (branch_taken_i) begin
                    pc_sel_o      = 1'b1;
                    if_id_flush_o = 1'b1;
                    w_flush_inc   = 1'b1;
                end else begin
                    pc_en_o = 1'b0;
                end
                if (resume_i) begin
                    w_state_d = StRun;
                end
            end
            default: begin
                w_state_d = StRun;
                w_cnt_d   = 4'd0;
            end
        endcase

        // Reset forces a frozen, fully-flushed front end regardless of state.
        if (!rst_n) begin
            pc_en_o       = 1'b0;
            pc_sel_o      = 1'b0;
            if_id_en_o    = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            halted_o      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_cnt       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + CntOne;
            end
            if (w_flush_inc) begin
                r_flush_cnt <= r_flush_cnt + CntOne;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two instances (1-cycle and 3-cycle load-use stall, the latter with
// 3-bit counters to exercise wrap) driven in lockstep; expectations queued per cycle.
module tb_pipeline_hazard_ctrl;

    // Control vector order: {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush, halted}
    localparam logic [5:0] CRst = 6'b000110;
    localparam logic [5:0] CRun = 6'b101000;
    localparam logic [5:0] CBr  = 6'b111110;
    localparam logic [5:0] CHbr = 6'b110111;
    localparam logic [5:0] CStl = 6'b000010;
    localparam logic [5:0] CNop = 6'b001100;
    localparam logic [5:0] CHlt = 6'b000011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, imem_valid;
    logic       halt_req, resume;

    logic        pc_en1, pc_sel1, if_id_en1, if_id_flush1, id_ex_flush1, halted1;
    logic        pc_en3, pc_sel3, if_id_en3, if_id_flush3, id_ex_flush3, halted3;
    logic [31:0] stall1, flush1;
    logic [2:0]  stall3, flush3;

    typedef struct {
        logic [5:0] c1;
        logic [5:0] c3;
        int         s1;
        int         s3;
        int         f;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   e_s1 = 0;
    int   e_s3 = 0;
    int   e_f  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
        .branch_taken_i(branch_taken), .imem_valid_i(imem_valid),
        .halt_req_i(halt_req), .resume_i(resume),
        .pc_en_o(pc_en1), .pc_sel_o(pc_sel1), .if_id_en_o(if_id_en1),
        .if_id_flush_o(if_id_flush1), .id_ex_flush_o(id_ex_flush1), .halted_o(halted1),
        .stall_cnt_o(stall1), .flush_cnt_o(flush1)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(3), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
        .branch_taken_i(branch_taken), .imem_valid_i(imem_valid),
        .halt_req_i(halt_req), .resume_i(resume),
        .pc_en_o(pc_en3), .pc_sel_o(pc_sel3), .if_id_en_o(if_id_en3),
        .if_id_flush_o(if_id_flush3), .id_ex_flush_o(id_ex_flush3), .halted_o(halted3),
        .stall_cnt_o(stall3), .flush_cnt_o(flush3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: compare the cycle's expectation midway between active edges.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".ctl1"},
                  {26'd0, pc_en1, pc_sel1, if_id_en1, if_id_flush1, id_ex_flush1, halted1},
                  {26'd0, e.c1});
            check({e.tag, ".ctl3"},
                  {26'd0, pc_en3, pc_sel3, if_id_en3, if_id_flush3, id_ex_flush3, halted3},
                  {26'd0, e.c3});
            check({e.tag, ".stall1"}, stall1, e.s1);
            check({e.tag, ".flush1"}, flush1, e.f);
            check({e.tag, ".stall3"}, {29'd0, stall3}, e.s3 % 8);
            check({e.tag, ".flush3"}, {29'd0, flush3}, e.f % 8);
        end
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; imem_valid = 1'b1; halt_req = 1'b0; resume = 1'b0;
    endtask

    // Push this cycle's expectation, then apply the counter deltas it implies.
    task automatic step(input logic [5:0] c1, input logic [5:0] c3, input int ds1,
                        input int ds3, input int df, input string tag);
        exp_t e;
        if (!rst_n) begin
            e_s1 = 0; e_s3 = 0; e_f = 0;
        end
        e.c1 = c1; e.c3 = c3; e.s1 = e_s1; e.s3 = e_s3; e.f = e_f; e.tag = tag;
        q.push_back(e);
        if (rst_n) begin
            e_s1 += ds1; e_s3 += ds3; e_f += df;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs1 = 5'h1f; id_rs2 = 5'h1f; ex_rd = 5'h1f;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; ex_mem_read = 1'b1;
        branch_taken = 1'b1; imem_valid = 1'b1; halt_req = 1'b1; resume = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step(CRst, CRst, 0, 0, 0, "reset");

        rst_n = 1'b1;
        idle();
        step(CRun, CRun, 0, 0, 0, "release");
        step(CRun, CRun, 0, 0, 0, "idle");

        // Load-use on rs1
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        step(CStl, CStl, 1, 1, 0, "lu_rs1");
        idle();
        step(CRun, CStl, 0, 1, 0, "lu_s2");
        step(CRun, CStl, 0, 1, 0, "lu_s3");
        step(CRun, CRun, 0, 0, 0, "lu_done");

        // x0 destination never interlocks
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        step(CRun, CRun, 0, 0, 0, "rd0");

        // Load-use on rs2, branch arrives on the second stall cycle
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        step(CStl, CStl, 1, 1, 0, "lu_rs2");
        idle();
        branch_taken = 1'b1;
        step(CBr, CBr, 0, 1, 1, "stall_br");
        idle();
        step(CRun, CRun, 0, 0, 0, "post_br");

        // Branch beats hazard and halt request
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        id_uses_rs1 = 1'b1; halt_req = 1'b1;
        step(CBr, CBr, 0, 0, 1, "br_prio");
        idle();
        step(CRun, CRun, 0, 0, 0, "br_no_halt");

        // Instruction memory wait states
        imem_valid = 1'b0;
        step(CNop, CNop, 0, 0, 0, "imem0");
        step(CNop, CNop, 0, 0, 0, "imem1");
        idle();
        step(CRun, CRun, 0, 0, 0, "imem_ok");

        // Another 3-cycle stall takes the 3-bit counter from 5 to 8, wrapping to 0
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        step(CStl, CStl, 1, 1, 0, "lu_wrap");
        idle();
        step(CRun, CStl, 0, 1, 0, "wrap_s2");
        step(CRun, CStl, 0, 1, 0, "wrap_s3");
        step(CRun, CRun, 0, 0, 0, "wrap_done");

        // Debug halt, drain branch, resume
        halt_req = 1'b1;
        step(CRun, CRun, 0, 0, 0, "halt_req");
        repeat (10) step(CHlt, CHlt, 0, 0, 0, "halted");
        halt_req = 1'b0; branch_taken = 1'b1;
        step(CHbr, CHbr, 0, 0, 1, "halt_br");
        branch_taken = 1'b0; resume = 1'b1; halt_req = 1'b1;
        step(CHlt, CHlt, 0, 0, 0, "resume");
        idle();
        step(CRun, CRun, 0, 0, 0, "resumed");

        // Reset while halted
        halt_req = 1'b1;
        step(CRun, CRun, 0, 0, 0, "halt_req2");
        step(CHlt, CHlt, 0, 0, 0, "halted2");
        rst_n = 1'b0;
        step(CRst, CRst, 0, 0, 0, "halt_rst");
        rst_n = 1'b1;
        idle();
        step(CRun, CRun, 0, 0, 0, "after_rst");

        @(negedge clk);
        #1;
        check("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
